branch_metric_gen: RTL

- Parametrised successor of the initial branch-metric stage of the SISO decoder.
- Consumes an interleaved systematic/parity LLR stream plus a-priori LLRs and produces both initial branch metrics per trellis step.
- Adds the following: block framing from a latched blklen, trellis-termination tail handling, saturating arithmetic with optional halving, an output ready/valid handshake with skid buffering, and a sticky a-priori protocol error flag.
- Sits between the input LLR buffer and the forward/backward recursion units.

---
 rtl/siso_pkg.sv | 23 ++
 rtl/bm_skid_buf.sv | 51 +++++
 rtl/branch_metric_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the SISO decoder branch-metric front end.
// Combinational helpers only; no timing or flow control lives here.
package siso_pkg;
    localparam int LLR_W = 16;
    localparam int BM_W  = 16;

    typedef logic signed [LLR_W-1:0] llr_t;
    typedef logic signed [BM_W-1:0]  bm_t;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} bmg_state_e;

    // Symmetric clamp to +/-(2^(out_w-1)-1); the most negative code is never emitted.
    function automatic logic signed [31:0] sat_bm(input logic signed [31:0] v, input int out_w);
        logic signed [31:0] mx;
        mx = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        if (v > mx)
            return mx;
        else if (v < -mx)
            return -mx;
        else
            return v;
    endfunction
endpackage

// File: rtl/bm_skid_buf.sv
// Two-entry valid/ready buffer for metric pairs; head is registered, 1 cycle push-to-out.
// Backpressure: fill count is exported so the producer can stop before overflow.
module bm_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         vld,
    output logic [1:0]   fill
);
    logic [W-1:0] mem0, mem1;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem0  <= '0;
            mem1  <= '0;
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) mem0 <= push_dat;
                    else               mem1 <= push_dat;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the count; new pair lands behind any survivor.
                    if (cnt_q == 2'd1) begin
                        mem0 <= push_dat;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = mem0;
    assign vld  = (cnt_q != 2'd0);
    assign fill = cnt_q;
endmodule

// File: rtl/branch_metric_gen.sv
// Initial branch metrics from interleaved sys/par LLRs plus a-priori; pair out 1 cycle after parity beat.
// Backpressure: 2-entry skid on the output; ready_in drops before a parity beat could overflow it.
module branch_metric_gen #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int BLKLEN_W = 13,
    parameter int TAIL     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic signed [IN_W-1:0]  apriori,
    input  logic                    valid_apriori,
    input  logic [BLKLEN_W-1:0]     blklen,
    input  logic                    scale_half,
    output logic signed [OUT_W-1:0] init_branch1_t,
    output logic signed [OUT_W-1:0] init_branch2_t,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    last_out,
    output logic                    err_apriori
);
    import siso_pkg::*;

    localparam int SW = IN_W + 2;
    localparam int PW = 2 * OUT_W + 1;

    bmg_state_e           state_q, state_d;
    logic [BLKLEN_W-1:0]  cnt_q, cnt_d, blen_q, blen_d;
    logic                 phase_q;
    logic signed [IN_W-1:0] sys_q;
    logic                 xfer, push, pop, last_step, err_set;
    logic [1:0]           fill;
    logic [PW-1:0]        push_dat, head;
    logic signed [SW-1:0] sys_x, par_x, apr_x, sum1, sum2, sc1, sc2;
    logic signed [31:0]   sat1, sat2;

    assign pop      = valid_out && ready_out;
    assign ready_in = rst && (fill != 2'd2) && !(fill == 2'd1 && !pop && phase_q);
    assign xfer     = valid_in && ready_in;

    assign sys_x = {{2{sys_q[IN_W-1]}}, sys_q};
    assign par_x = {{2{in[IN_W-1]}}, in};
    assign apr_x = (state_q == siso_pkg::DATA && valid_apriori) ? {{2{apriori[IN_W-1]}}, apriori} : '0;
    assign sum1  = sys_x + apr_x + par_x;
    assign sum2  = sys_x + apr_x - par_x;
    assign sc1   = scale_half ? (sum1 >>> 1) : sum1;
    assign sc2   = scale_half ? (sum2 >>> 1) : sum2;
    assign sat1  = sat_bm(32'(sc1), OUT_W);
    assign sat2  = sat_bm(32'(sc2), OUT_W);
    assign push_dat = {sat1[OUT_W-1:0], sat2[OUT_W-1:0], last_step};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blen_d    = blen_q;
        push      = 1'b0;
        last_step = 1'b0;
        err_set   = 1'b0;
        if (xfer) begin
            if (!phase_q) begin
                // A-priori is only meaningful alongside the parity beat.
                if (valid_apriori) err_set = 1'b1;
                if (state_q == siso_pkg::IDLE) begin
                    blen_d  = blklen;
                    cnt_d   = '0;
                    state_d = (blklen == '0) ? siso_pkg::TAIL : siso_pkg::DATA;
                end
            end else begin
                push = 1'b1;
                if (state_q == siso_pkg::DATA) begin
                    if (!valid_apriori) err_set = 1'b1;
                    if (cnt_q == blen_q - 1'b1) begin
                        state_d = siso_pkg::TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (valid_apriori) err_set = 1'b1;
                    if (cnt_q == BLKLEN_W'(TAIL - 1)) begin
                        last_step = 1'b1;
                        state_d   = siso_pkg::IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= siso_pkg::IDLE;
            cnt_q   <= '0;
            blen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= 1'b0;
            sys_q       <= '0;
            err_apriori <= 1'b0;
        end else begin
            if (xfer)             phase_q     <= !phase_q;
            if (xfer && !phase_q) sys_q       <= in;
            if (err_set)          err_apriori <= 1'b1;
        end
    end

    bm_skid_buf #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .vld      (valid_out),
        .fill     (fill)
    );

    assign init_branch1_t = head[PW-1 -: OUT_W];
    assign init_branch2_t = head[OUT_W:1];
    assign last_out       = head[0];
endmodule
